// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pe_pkg
//  Purpose  : Shared types and constants for the parallel_pe sequencer:
//             sequencer state encoding, PE vector/result widths and the
//             bit positions of the PE control word.
//  Revision : 1.0 - initial release
// ============================================================================
package pe_pkg;

    // Width of one neuron or weight vector consumed by parallel_pe per beat
    localparam int c_pe_vec_w  = 512;

    // Default width of one PE accumulation result
    localparam int c_res_w     = 32;

    // Bit positions inside the 2-bit PE control word
    localparam int c_ctl_first = 0;
    localparam int c_ctl_last  = 1;

    // Sequencer states, explicitly encoded
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } pe_seq_state_t;

endpackage : pe_pkg
`default_nettype wire

// File: rtl/pe_seq_beat_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pe_seq_beat_gen
//  Purpose  : Beat generator for one instruction. A load pulse captures the
//             accumulation length; each enabled cycle then advances the beat
//             counter and produces registered first/last flags plus an
//             end-of-instruction strobe on the final beat.
//  Revision : 1.0 - initial release
// ============================================================================
module pe_seq_beat_gen #(
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ITER_W-1:0] len,
    input  logic              en,
    output logic              active,
    output logic              first,
    output logic              last,
    output logic              eoi
);

    localparam int c_w1 = ITER_W + 1;

    logic [ITER_W-1:0] r_len;
    logic [ITER_W-1:0] r_iter;
    logic              r_active;
    logic              r_first;
    logic              r_last;

    // Index of the beat after next, widened so len = 2^ITER_W-1 cannot overflow
    logic [c_w1-1:0]   w_iter_p2;

    assign w_iter_p2 = {1'b0, r_iter} + c_w1'(2);

    // Beat counter with first/last flags precomputed one cycle ahead
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len    <= '0;
            r_iter   <= '0;
            r_active <= 1'b0;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
        end else if (load) begin
            r_len    <= len;
            r_iter   <= '0;
            r_active <= (len != '0);
            r_first  <= (len != '0);
            r_last   <= (len == ITER_W'(1));
        end else if (en && r_active) begin
            if (r_last) begin
                r_iter   <= '0;
                r_active <= 1'b0;
                r_first  <= 1'b0;
                r_last   <= 1'b0;
            end else begin
                r_iter   <= r_iter + ITER_W'(1);
                r_first  <= 1'b0;
                r_last   <= (w_iter_p2 == {1'b0, r_len});
            end
        end
    end

    assign active = r_active;
    assign first  = r_first;
    assign last   = r_last;
    assign eoi    = r_active & en & r_last;

endmodule : pe_seq_beat_gen
`default_nettype wire

// File: rtl/pe_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pe_seq_ctrl
//  Purpose  : Sequencer for parallel_pe. Walks INST_NUM accumulation-length
//             instructions, drives the shared neuron/weight read address and
//             the PE first/last/valid controls, and writes every returned PE
//             result into the result buffer in issue order.
//             Optional macro PE_SEQ_PERF_EN adds busy-cycle and beat
//             counters (perf_cycles / perf_beats).
//  Revision : 1.0 - initial release
// ============================================================================
module pe_seq_ctrl
    import pe_pkg::*;
#(
    parameter int INST_NUM = 4,
    parameter int INST_AW  = 2,
    parameter int ADDR_W   = 16,
    parameter int ITER_W   = 8,
    parameter int RES_W    = c_res_w
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [INST_AW-1:0] inst_addr,
    input  logic [ITER_W-1:0]  inst_data,
    output logic [ADDR_W-1:0]  nw_addr,
    output logic [1:0]         pe_ctl,
    output logic               pe_vld_i,
    input  logic               pe_vld_o,
    input  logic [RES_W-1:0]   pe_result,
    output logic               res_we,
    output logic [INST_AW-1:0] res_addr,
    output logic [RES_W-1:0]   res_wdata
`ifdef PE_SEQ_PERF_EN
    ,
    output logic [31:0]        perf_cycles,
    output logic [31:0]        perf_beats
`endif
);

    // Issued/received counts must reach INST_NUM, so one extra bit
    localparam int                 c_cnt_w    = INST_AW + 1;
    localparam logic [INST_AW-1:0] c_last_ptr = INST_AW'(INST_NUM - 1);

    pe_seq_state_t       r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [INST_AW-1:0]  r_inst_ptr;
    logic [ADDR_W-1:0]   r_nw_addr;
    logic [c_cnt_w-1:0]  r_issued;
    logic [c_cnt_w-1:0]  r_received;

    logic                w_start_acc;
    logic                w_fetch_zero;
    logic                w_load;
    logic                w_issue;
    logic                w_last_inst;
    logic                w_active;
    logic                w_first;
    logic                w_last;
    logic                w_eoi;
    logic                w_res_hit;
    logic                w_res_ok;
    logic                w_res_spur;

    assign w_start_acc  = (r_state == ST_IDLE) && start;
    assign w_fetch_zero = (r_state == ST_FETCH) && (inst_data == '0);
    assign w_load       = (r_state == ST_FETCH) && (inst_data != '0);
    assign w_issue      = (r_state == ST_ISSUE);
    assign w_last_inst  = (r_inst_ptr == c_last_ptr);

    // A result is only legal while something is still outstanding
    assign w_res_hit    = pe_vld_o && (r_state != ST_IDLE);
    assign w_res_ok     = w_res_hit && (r_received != r_issued);
    assign w_res_spur   = w_res_hit && (r_received == r_issued);

    pe_seq_beat_gen #(
        .ITER_W (ITER_W)
    ) u_beat_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .len    (inst_data),
        .en     (w_issue),
        .active (w_active),
        .first  (w_first),
        .last   (w_last),
        .eoi    (w_eoi)
    );

    // Run sequencing, address walk, instruction pointer and result bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_inst_ptr <= '0;
            r_nw_addr  <= '0;
            r_issued   <= '0;
            r_received <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_acc) begin
                        r_state    <= ST_FETCH;
                        r_busy     <= 1'b1;
                        r_err      <= 1'b0;
                        r_nw_addr  <= base_addr;
                        r_inst_ptr <= '0;
                        r_issued   <= '0;
                        r_received <= '0;
                    end
                end
                ST_FETCH: begin
                    if (w_fetch_zero) begin
                        // Zero-length instruction: flag it and skip, no result slot
                        r_err      <= 1'b1;
                        r_inst_ptr <= r_inst_ptr + INST_AW'(1);
                        r_state    <= w_last_inst ? ST_DRAIN : ST_FETCH;
                    end else begin
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_nw_addr <= r_nw_addr + ADDR_W'(1);
                    if (w_eoi) begin
                        r_issued   <= r_issued + c_cnt_w'(1);
                        r_inst_ptr <= r_inst_ptr + INST_AW'(1);
                        r_state    <= w_last_inst ? ST_DRAIN : ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (r_received == r_issued) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Result capture runs alongside whatever state is active
            if (w_res_ok) begin
                r_received <= r_received + c_cnt_w'(1);
            end
            if (w_res_spur) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign inst_addr = r_inst_ptr;
    assign nw_addr   = r_nw_addr;
    assign pe_vld_i  = w_active;

    always_comb begin
        pe_ctl              = 2'b00;
        pe_ctl[c_ctl_first] = w_first;
        pe_ctl[c_ctl_last]  = w_last;
    end

    // Result buffer write port, quiet whenever nothing is being written
    assign res_we    = w_res_ok;
    assign res_addr  = w_res_ok ? r_received[INST_AW-1:0] : '0;
    assign res_wdata = w_res_ok ? pe_result : '0;

`ifdef PE_SEQ_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_beats;

    // Saturating busy-cycle and beat counters, frozen between runs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_cycles <= '0;
            r_perf_beats  <= '0;
        end else if (w_start_acc) begin
            r_perf_cycles <= '0;
            r_perf_beats  <= '0;
        end else begin
            if (r_busy && (r_perf_cycles != '1)) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
            if (w_active && (r_perf_beats != '1)) begin
                r_perf_beats <= r_perf_beats + 32'd1;
            end
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_beats  = r_perf_beats;
`endif

endmodule : pe_seq_ctrl
`default_nettype wire

// File: doc/pe_seq_ctrl.md
Name: pe_seq_ctrl

Overview:
- Sequencer for parallel_pe, which takes one 512-bit neuron and one 512-bit weight vector per cycle.
- Walks an instruction list where each entry is an 8-bit accumulation length.
- Per operation: drives linear neuron/weight buffer read addresses, generates PE ctl (first/last) and vld_i, captures each PE result into a result buffer.
- Sits between the on-chip neuron/weight/instruction buffers and parallel_pe; started by the top-level controller.

Parameters:
- INST_NUM, 4, number of instructions per run.
- INST_AW, 2, instruction/result address width (log2 INST_NUM).
- ADDR_W, 16, neuron/weight buffer address width.
- ITER_W, 8, instruction length width.
- RES_W, 32, PE result width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run request; ignored unless IDLE.
- base_addr  in  ADDR_W  first neuron/weight address, sampled on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at run completion.
- err  out  1  sticky error; cleared on accepted start.
- inst_addr  out  INST_AW  instruction buffer address (combinational-read buffer).
- inst_data  in  ITER_W  accumulation length at inst_addr.
- nw_addr  out  ADDR_W  shared neuron/weight read address (combinational-read buffers).
- pe_ctl  out  2  [0]=first beat, [1]=last beat of the current instruction.
- pe_vld_i  out  1  PE input valid.
- pe_vld_o  in  1  PE result valid.
- pe_result  in  RES_W  PE result.
- res_we  out  1  result buffer write enable.
- res_addr  out  INST_AW  result buffer write address.
- res_wdata  out  RES_W  result buffer write data.

Behaviour:
- Reset values:
  - State = IDLE.
  - All outputs 0.
  - Internal counters (iter, inst pointer, address, issued, received) 0.
- States and transitions:
  - IDLE: on start → FETCH. Latch base_addr into nw_addr, clear inst pointer, issued/received counts and err.
  - FETCH (1 cycle): latch len = inst_data at inst_addr.
    - len == 0: set err, skip (no PE beats, no result expected), advance pointer; go to FETCH, or to DRAIN if this was the last instruction.
    - Otherwise → ISSUE with iter = 0.
  - ISSUE: every cycle pe_vld_i = 1.
    - pe_ctl[0] = (iter == 0); pe_ctl[1] = (iter == len-1); both high when len == 1.
    - nw_addr and iter increment each beat.
    - On the last beat, issued count increments; go to FETCH, or to DRAIN after instruction INST_NUM-1.
    - nw_addr continues linearly across instructions with no gap and wraps modulo 2^ADDR_W.
  - DRAIN: wait until received == issued → DONE.
  - DONE: done = 1 for one cycle, busy drops the same cycle → IDLE.
- Timing:
  - First beat is issued 2 cycles after accepted start.
  - Each instruction costs len + 1 cycles (one fetch bubble).
- Result capture: accepted in every state except IDLE.
  - On pe_vld_o: res_we = 1 in the same cycle, res_wdata = pe_result, res_addr = received count; then received increments.
  - Results map in issue order; skipped instructions leave their res_addr slot unwritten and later results shift down.
- Simultaneous pe_vld_o and the state's last beat: both take effect.
- pe_vld_o with received == issued sets err and does not write.
- pe_vld_o in IDLE is ignored and does not set err.
- start during a run is ignored.
- rst mid-run: immediate return to reset values. Any beats in flight inside the PE are lost; the PE shares the same reset.

Optional Feature:
- Macro PE_SEQ_PERF_EN.
- Defined:
  - Adds outputs perf_cycles[31:0] (cycles spent busy) and perf_beats[31:0] (pe_vld_i beats).
  - Both clear on accepted start, saturate at all-ones, and hold after done.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pe_pkg holds:
  - State encoding constants: IDLE, FETCH, ISSUE, DRAIN, DONE.
  - PE_VEC_W = 512 and RES_W defaults.
  - CTL_FIRST = 0, CTL_LAST = 1 bit indices.
- One sub-module, pe_seq_beat_gen: from len and an enable, produces iter, the first/last flags and end-of-instruction.
- FSM, address and result logic stay in pe_seq_ctrl.

Test Plan:
- Lengths {20,30,40,50}, base 0, PE model with 4-cycle latency:
  - 140 beats with nw_addr 0..139.
  - first at addresses 0x00/0x14/0x32/0x5A; last at 0x13/0x31/0x59/0x8B.
  - 4 result writes at res_addr 0..3; done at or after cycle 146; err = 0.
- Lengths {1,1,1,1}: every beat has pe_ctl = 2'b11; 4 beats, each separated by one bubble.
- Lengths {5,0,3,2}: err = 1; 10 beats; 3 results written to res_addr 0..2; done still pulses.
- Base 0xFFFE, lengths {4,…}: nw_addr sequence FFFE, FFFF, 0000, 0001.
- rst asserted during the second instruction: all outputs 0 next edge. A new start then runs cleanly from instruction 0.
- Spurious pe_vld_o during FETCH with no outstanding beats → err = 1, res_we stays 0.
